// File: rtl/legendre_rom_arbiter_pkg.sv
// legendre_rom_arbiter_pkg: shared widths, ROM depth and the round-robin pick helper
package legendre_rom_arbiter_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_REQ = 16;
    localparam int PTR_W = 4;
    localparam int AGE_W = 4;
    localparam int LEGENDRE_ROM_DEPTH = 641;
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req_vec, input logic [PTR_W-1:0] ptr, input int n);
        logic [MAX_REQ-1:0] mask, rot, oh;
        logic [2*MAX_REQ-1:0] dbl, back;
        mask = MAX_REQ'((32'd1 << n) - 32'd1);
        dbl = ({{MAX_REQ{1'b0}}, req_vec & mask} << n) | {{MAX_REQ{1'b0}}, req_vec & mask};
        rot = MAX_REQ'(dbl >> ptr) & mask;
        oh = rot & (-rot);
        back = {{MAX_REQ{1'b0}}, oh} << ptr;
        return (back[MAX_REQ-1:0] | MAX_REQ'(back >> n)) & mask;
    endfunction
endpackage

// File: rtl/legendre_rom_arbiter_if.sv
// legendre_rom_arbiter_if: requester-side read bus shared by all PRN generator ports
interface legendre_rom_arbiter_if #(
    parameter int NUM_REQ = 8,
    parameter int ADDR_W = legendre_rom_arbiter_pkg::DEF_ADDR_W,
    parameter int DATA_W = legendre_rom_arbiter_pkg::DEF_DATA_W
) ();
    logic [NUM_REQ-1:0] req_rd, req_preempt, req_valid, data_owner;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] legendre_data;
    modport master(output req_rd, req_preempt, req_addr, input req_valid, legendre_data, data_owner);
    modport slave(input req_rd, req_preempt, req_addr, output req_valid, legendre_data, data_owner);
endinterface

// File: rtl/legendre_rr_pick.sv
// legendre_rr_pick: one-hot pick of the first request at or after ptr, wrapping modulo N
module legendre_rr_pick import legendre_rom_arbiter_pkg::*; #(
    parameter int N = 8
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);
    assign gnt = N'(rr_pick(MAX_REQ'(req), ptr, N));
endmodule

// File: rtl/legendre_rom_arbiter.sv
// legendre_rom_arbiter: shares one Legendre ROM among NUM_REQ read ports (urgent, aged, round-robin)
module legendre_rom_arbiter import legendre_rom_arbiter_pkg::*; #(
    parameter int NUM_REQ = 8,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int AGE_MAX = 15
) (
    input  logic                  clk,
    input  logic                  rst_b,
    legendre_rom_arbiter_if.slave bus,
    output logic                  rom_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic                  rom_busy,
    input  logic [DATA_W-1:0]     rom_q
);
    logic live;
    logic [PTR_W-1:0] rr_ptr, ptr_nxt;
    logic [AGE_W-1:0] age [NUM_REQ];
    logic [NUM_REQ-1:0] elig, aged, urg, gnt_u, gnt_n, gnt, owner_q;
    logic [ADDR_W-1:0] addr_q, win_addr;
    assign elig = bus.req_rd & ~{NUM_REQ{rom_busy | ~live | ~rst_b}};
    assign urg = elig & (bus.req_preempt | aged);
    legendre_rr_pick #(.N(NUM_REQ)) u_pick_urg (.req(urg), .ptr(rr_ptr), .gnt(gnt_u));
    legendre_rr_pick #(.N(NUM_REQ)) u_pick_norm (.req(elig), .ptr(rr_ptr), .gnt(gnt_n));
    assign gnt = |urg ? gnt_u : gnt_n;
    always_comb begin
        win_addr = '0;
        ptr_nxt = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            aged[i] = age[i] == AGE_W'(AGE_MAX);
            if (gnt[i]) begin
                win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end
    assign bus.req_valid = gnt;
    assign rom_en = |gnt;
    assign rom_addr = rom_en ? win_addr : rst_b ? addr_q : '0;
    assign bus.data_owner = rst_b ? owner_q : '0;
    assign bus.legendre_data = rom_q;
    // live stays low for the first cycle after reset release, holding off grants
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            live <= 1'b0;
            rr_ptr <= '0;
            addr_q <= '0;
            owner_q <= '0;
        end else begin
            live <= 1'b1;
            rr_ptr <= ptr_nxt;
            owner_q <= gnt;
            if (rom_en) addr_q <= win_addr;
        end
    end
    always_ff @(posedge clk)
        for (int i = 0; i < NUM_REQ; i++)
            age[i] <= (!rst_b || !bus.req_rd[i] || gnt[i]) ? '0 : aged[i] ? age[i] : age[i] + AGE_W'(1);
endmodule

// File: tb/tb_legendre_rom_arbiter.sv
// tb_legendre_rom_arbiter: directed and random stimulus checked against a behavioural arbiter model
module tb_legendre_rom_arbiter;
    logic clk = 0, rst_b = 0, rom_busy = 0;
    logic rom_en;
    logic [9:0] rom_addr;
    logic [15:0] rom_q = 0;
    int n_checks = 0, n_fail = 0, hit;
    logic [7:0] g, v1;
    int m_age [8];
    int m_ptr, w;
    bit m_live;
    logic [7:0] m_owner, elig, urg, exp_v, exp_o;
    logic [9:0] m_last, exp_a;
    logic [15:0] m_data;
    logic [7:0] seq2 [6] = '{8'h01, 8'h04, 8'h20, 8'h01, 8'h04, 8'h20};

    legendre_rom_arbiter_if #(.NUM_REQ(8), .ADDR_W(10), .DATA_W(16)) bus ();
    legendre_rom_arbiter #(.NUM_REQ(8), .ADDR_W(10), .DATA_W(16), .AGE_MAX(15)) dut (
        .clk(clk), .rst_b(rst_b), .bus(bus), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_busy(rom_busy), .rom_q(rom_q));

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_en) rom_q <= {6'h0, rom_addr} ^ 16'h5A5A;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [9:0] a);
        bus.req_addr[p*10 +: 10] = a;
    endtask

    function automatic int pick(input logic [7:0] set, input int ptr);
        for (int j = 0; j < 8; j++)
            if (set[(ptr + j) % 8]) return (ptr + j) % 8;
        return -1;
    endfunction

    // reference model: evaluated mid-cycle, state advanced on each rising edge
    initial begin
        m_ptr = 0; m_live = 0; m_owner = 0; m_last = 0; m_data = 0;
        foreach (m_age[i]) m_age[i] = 0;
        forever begin
            @(negedge clk);
            elig = (rst_b && m_live && !rom_busy) ? bus.req_rd : 8'h00;
            for (int i = 0; i < 8; i++) urg[i] = elig[i] && (bus.req_preempt[i] || m_age[i] == 15);
            w = pick(urg != 0 ? urg : elig, m_ptr);
            if (w >= 0) begin
                exp_v = 8'(1 << w);
                exp_a = bus.req_addr[w*10 +: 10];
            end else begin
                exp_v = 8'h00;
                exp_a = rst_b ? m_last : 10'h0;
            end
            exp_o = rst_b ? m_owner : 8'h00;
            check("req_valid", bus.req_valid, exp_v);
            check("rom_en", rom_en, w >= 0);
            check("rom_addr", rom_addr, exp_a);
            check("data_owner", bus.data_owner, exp_o);
            if (exp_o != 0) check("legendre_data", bus.legendre_data, m_data);
            @(posedge clk);
            if (!rst_b) begin
                m_ptr = 0; m_live = 0; m_owner = 0; m_last = 0;
                foreach (m_age[i]) m_age[i] = 0;
            end else begin
                m_live = 1;
                for (int i = 0; i < 8; i++)
                    m_age[i] = (!bus.req_rd[i] || i == w) ? 0 : (m_age[i] < 15 ? m_age[i] + 1 : 15);
                m_owner = exp_v;
                if (w >= 0) begin
                    m_ptr = (w + 1) % 8;
                    m_last = exp_a;
                    m_data = {6'h0, exp_a} ^ 16'h5A5A;
                end
            end
        end
    end

    initial begin
        bus.req_rd = 0; bus.req_preempt = 0; bus.req_addr = 0;
        repeat (2) tick();
        rst_b = 1;
        tick();
        set_addr(3, 10'h12A);
        bus.req_rd = 8'h08;
        @(negedge clk);
        check("t1_valid", bus.req_valid, 8'h08);
        check("t1_addr", rom_addr, 10'h12A);
        tick();
        bus.req_rd = 8'h00;
        @(negedge clk);
        check("t1_owner", bus.data_owner, 8'h08);
        check("t1_data", bus.legendre_data, 16'h5B70);
        tick();
        bus.req_rd = 8'h80;
        tick();
        bus.req_rd = 8'h25;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_grant", bus.req_valid, seq2[k]);
            check("t2_en", rom_en, 1'b1);
            tick();
        end
        bus.req_rd = 8'h02;
        tick();
        bus.req_rd = 8'h42; bus.req_preempt = 8'h40;
        @(negedge clk);
        check("t3_first", bus.req_valid, 8'h40);
        tick();
        bus.req_rd = 8'h02; bus.req_preempt = 8'h00;
        @(negedge clk);
        check("t3_second", bus.req_valid, 8'h02);
        tick();
        bus.req_rd = 8'h01;
        tick();
        bus.req_rd = 8'h13; bus.req_preempt = 8'h03; hit = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.req_valid[4] && hit == 0) hit = c;
            tick();
            if (hit != 0) bus.req_rd[4] = 1'b0;
        end
        check("t4_age_grant_cycle", hit, 16);
        bus.req_rd = 8'h81; bus.req_preempt = 8'h00; rom_busy = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_busy_valid", bus.req_valid, 8'h00);
            check("t5_busy_en", rom_en, 1'b0);
            tick();
        end
        rom_busy = 0;
        @(negedge clk);
        v1 = bus.req_valid;
        check("t5_first", v1, 8'h80);
        tick();
        bus.req_rd = 8'h01;
        @(negedge clk);
        check("t5_second", bus.req_valid, 8'h01);
        tick();
        bus.req_rd = 8'h04;
        @(negedge clk);
        check("t6_grant", bus.req_valid, 8'h04);
        tick();
        rst_b = 0;
        @(negedge clk);
        check("t6_rst_valid", bus.req_valid, 8'h00);
        check("t6_rst_owner", bus.data_owner, 8'h00);
        tick();
        rst_b = 1;
        @(negedge clk);
        check("t6_owner", bus.data_owner, 8'h00);
        check("t6_idle_valid", bus.req_valid, 8'h00);
        check("t6_idle_en", rom_en, 1'b0);
        tick();
        @(negedge clk);
        check("t6_regrant", bus.req_valid, 8'h04);
        tick();
        bus.req_rd = 8'h00;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            g = bus.req_valid;
            tick();
            for (int p = 0; p < 8; p++) begin
                if (g[p]) bus.req_rd[p] = ($urandom % 4) == 0;
                else if (!bus.req_rd[p]) bus.req_rd[p] = ($urandom % 3) == 0;
                if ($urandom % 6 == 0) set_addr(p, 10'($urandom));
                bus.req_preempt[p] = ($urandom % 8) == 0;
            end
            rom_busy = ($urandom % 10) == 0;
            rst_b = ($urandom % 97) != 0;
        end
        rst_b = 1; rom_busy = 0; bus.req_rd = 0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
